// File: rtl/l2_pmem_pkg.sv
// Shared types and default geometry for the L2 physical-memory port.
package l2_pmem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 256;
  localparam int unsigned BEAT_W_DEF = 64;
  localparam int unsigned BEATS      = LINE_W_DEF / BEAT_W_DEF;
  localparam int unsigned BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/l2_line_buffer.sv
// Line-wide holding register: full-line load, per-beat slice write, beat-indexed slice read.
module l2_line_buffer #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [LINE_W-1:0] i_line,
  input  logic              i_beat_we,
  input  logic [IDX_W-1:0]  i_beat_idx,
  input  logic [BEAT_W-1:0] i_beat,
  output logic [LINE_W-1:0] o_line,
  output logic [BEAT_W-1:0] o_beat
);

  localparam int unsigned LW_IDX = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  logic [LINE_W-1:0] r_line;
  logic [LW_IDX-1:0] w_base;

  // Bit offset of the selected beat; beat 0 sits in the LSBs.
  assign w_base = LW_IDX'(i_beat_idx) * LW_IDX'(BEAT_W);

  // Full-line load has priority over a single-beat update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_line;
    end else if (i_beat_we) begin
      r_line[w_base +: BEAT_W] <= i_beat;
    end
  end

  assign o_line = r_line;
  assign o_beat = r_line[w_base +: BEAT_W];

endmodule

// File: rtl/l2_pmem_burst_responder.sv
// Turns L2 whole-line read/write requests into fixed-length beat bursts on the memory bus.
module l2_pmem_burst_responder
  import l2_pmem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned BEAT_W = BEAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int unsigned       N_BEATS    = LINE_W / BEAT_W;
  localparam int unsigned       IDX_W      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int unsigned       LW_IDX     = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [IDX_W-1:0]  LAST_BEAT  = IDX_W'(N_BEATS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_beat, w_beat_nxt;
  logic [ADDR_W-1:0]   r_mem_address, w_addr_nxt;
  logic                r_mem_read, r_mem_write, r_pmem_resp;
  logic [LINE_W-1:0]   r_pmem_rdata;
  logic                w_buf_load, w_buf_beat_we, w_rd_done;
  logic [LINE_W-1:0]   w_buf_line, w_rd_line;
  logic [BEAT_W-1:0]   w_buf_beat;
  logic [LW_IDX-1:0]   w_rd_base;

  l2_line_buffer #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .IDX_W  (IDX_W)
  ) u_line_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_buf_load),
    .i_line     (pmem_wdata),
    .i_beat_we  (w_buf_beat_we),
    .i_beat_idx (r_beat),
    .i_beat     (mem_rdata),
    .o_line     (w_buf_line),
    .o_beat     (w_buf_beat)
  );

  // Next state, beat counter, address latch and buffer controls; write wins over read in IDLE.
  always_comb begin
    w_state_nxt   = r_state;
    w_beat_nxt    = r_beat;
    w_addr_nxt    = r_mem_address;
    w_buf_load    = 1'b0;
    w_buf_beat_we = 1'b0;
    w_rd_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (pmem_write) begin
          w_state_nxt = WRITE;
          w_addr_nxt  = pmem_address & ALIGN_MASK;
          w_beat_nxt  = '0;
          w_buf_load  = 1'b1;
        end else if (pmem_read) begin
          w_state_nxt = READ;
          w_addr_nxt  = pmem_address & ALIGN_MASK;
          w_beat_nxt  = '0;
        end
      end
      READ: begin
        if (mem_resp) begin
          w_buf_beat_we = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = DONE;
            w_rd_done   = 1'b1;
          end else begin
            w_beat_nxt = r_beat + IDX_W'(1);
          end
        end
      end
      WRITE: begin
        if (mem_resp) begin
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = DONE;
          end else begin
            w_beat_nxt = r_beat + IDX_W'(1);
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Completed read line: buffered beats with the final beat merged straight from the bus.
  assign w_rd_base = LW_IDX'(r_beat) * LW_IDX'(BEAT_W);

  always_comb begin
    w_rd_line                        = w_buf_line;
    w_rd_line[w_rd_base +: BEAT_W]   = mem_rdata;
  end

  // State, counter, address and strobes; strobes come from the next state so they are pure flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_beat        <= '0;
      r_mem_address <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_pmem_resp   <= 1'b0;
      r_pmem_rdata  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_beat        <= w_beat_nxt;
      r_mem_address <= w_addr_nxt;
      r_mem_read    <= (w_state_nxt == READ);
      r_mem_write   <= (w_state_nxt == WRITE);
      r_pmem_resp   <= (w_state_nxt == DONE);
      if (w_rd_done) begin
        r_pmem_rdata <= w_rd_line;
      end
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign pmem_resp   = r_pmem_resp;
  assign mem_address = r_mem_address;
  assign mem_wdata   = w_buf_beat;
  assign pmem_rdata  = r_pmem_rdata;

endmodule

// File: tb/tb_l2_pmem_burst_responder.sv
// Scoreboard bench: line-level memory model predicts L2 responses; a beat-level memory device drives the bus.
`timescale 1ns/1ps
module tb_l2_pmem_burst_responder;
  import l2_pmem_pkg::*;

  localparam int unsigned AW = ADDR_W_DEF;
  localparam int unsigned LW = LINE_W_DEF;
  localparam int unsigned BW = BEAT_W_DEF;

  typedef struct {
    bit          is_read;
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata, pmem_rdata;
  logic          pmem_resp, mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_wdata;
  logic [BW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;

  int checks = 0;
  int errors = 0;

  txn_t          exp_q[$];
  txn_t          obs_q[$];
  logic [LW-1:0] ref_mem [logic [AW-1:0]];
  logic [LW-1:0] dev_mem [logic [AW-1:0]];
  logic [LW-1:0] last_rd = '0;

  int  mode = 0;
  bit  spur_en = 1'b0;
  bit  spur_all = 1'b0;

  logic                dev_busy = 1'b0;
  logic [BEAT_IDX_W:0] dev_cnt = '0;
  logic [AW-1:0]       dev_addr = '0;
  bit                  dev_is_read = 1'b0;
  logic [LW-1:0]       dev_wline = '0;
  bit                  ack_tog = 1'b0;
  bit                  dev_ack;
  logic [LW-1:0]       dev_line_v;
  txn_t                dev_t;
  txn_t                mon_e, mon_o;

  l2_pmem_burst_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endfunction

  function automatic logic [AW-1:0] line_base(input logic [AW-1:0] a);
    return a - (a % AW'(LW / 8));
  endfunction

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < int'(LW / 32); i++)
      l = (l << 32) | LW'((a * 32'h9E37_79B1) ^ (32'(i) * 32'h85EB_CA6B));
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < int'(LW / 32); i++) l = (l << 32) | LW'($urandom);
    return l;
  endfunction

  function automatic logic [LW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic logic [LW-1:0] dev_rd(input logic [AW-1:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_line(a);
  endfunction

  // Memory device: acks beats per wait mode, serves/collects beats, reports each finished burst.
  always @(negedge clk) begin
    if (!rst_n) begin
      dev_busy = 1'b0;
      dev_cnt  = '0;
      mem_resp = 1'b0;
    end else if (mem_read || mem_write) begin
      if (!dev_busy) begin
        dev_busy    = 1'b1;
        dev_cnt     = '0;
        dev_addr    = mem_address;
        dev_is_read = mem_read;
        dev_wline   = '0;
        ack_tog     = 1'b0;
      end
      case (mode)
        0: dev_ack = 1'b1;
        1: begin dev_ack = ack_tog; ack_tog = ~ack_tog; end
        default: dev_ack = ($urandom_range(0, 2) != 0);
      endcase
      mem_resp  = 1'b0;
      mem_rdata = BW'({$urandom, $urandom});
      if (dev_ack && int'(dev_cnt) < int'(BEATS)) begin
        mem_resp = 1'b1;
        if (dev_is_read) begin
          dev_line_v = dev_rd(dev_addr);
          mem_rdata  = BW'(dev_line_v >> (int'(dev_cnt) * BW));
        end else begin
          dev_wline = dev_wline | (LW'(mem_wdata) << (int'(dev_cnt) * BW));
        end
        dev_cnt = dev_cnt + 1'b1;
        if (int'(dev_cnt) == int'(BEATS)) begin
          if (!dev_is_read) dev_mem[dev_addr] = dev_wline;
          dev_t.is_read = dev_is_read;
          dev_t.addr    = dev_addr;
          dev_t.line    = dev_wline;
          obs_q.push_back(dev_t);
        end
      end
    end else begin
      dev_busy  = 1'b0;
      mem_resp  = spur_all || (spur_en && ($urandom_range(0, 3) == 0));
      mem_rdata = BW'({$urandom, $urandom});
    end
  end

  // Monitor: every pmem_resp retires one expected transaction and its observed burst.
  always @(negedge clk) begin
    if (rst_n && pmem_resp) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", LW'(1), LW'(0));
      end else begin
        mon_e = exp_q.pop_front();
        if (obs_q.size() == 0) begin
          chk("burst_missing", LW'(0), LW'(1));
        end else begin
          mon_o = obs_q.pop_front();
          chk("burst_kind", LW'(mon_o.is_read), LW'(mon_e.is_read));
          chk("mem_address", LW'(mon_o.addr), LW'(mon_e.addr));
          if (!mon_e.is_read) chk("write_beats", mon_o.line, mon_e.line);
        end
        if (mon_e.is_read) begin
          chk("pmem_rdata", pmem_rdata, mon_e.line);
          last_rd = mon_e.line;
        end else begin
          chk("rdata_hold", pmem_rdata, last_rd);
        end
      end
    end
  end

  // One L2 transaction (or a write+read pair); returns cycles to the first pmem_resp.
  task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input int drop_at, input int gap, output int lat);
    txn_t          t;
    logic [LW-1:0] wd;
    int            need, nresp;
    wd = rand_line();
    repeat (gap) @(negedge clk);
    @(negedge clk);
    if (wr) begin
      t.is_read = 1'b0; t.addr = line_base(a); t.line = wd;
      exp_q.push_back(t);
      ref_mem[line_base(a)] = wd;
    end
    if (rd) begin
      t.is_read = 1'b1; t.addr = line_base(a); t.line = ref_rd(line_base(a));
      exp_q.push_back(t);
    end
    pmem_address = a;
    pmem_wdata   = wd;
    pmem_write   = wr;
    pmem_read    = rd;
    need  = int'(rd) + int'(wr);
    nresp = 0;
    lat   = 0;
    for (int c = 1; c <= 300 && nresp < need; c++) begin
      @(posedge clk); #1;
      if (c == drop_at) begin pmem_read = 1'b0; pmem_write = 1'b0; end
      if (pmem_resp) begin
        nresp++;
        if (lat == 0) lat = c;
        if (pmem_write) pmem_write = 1'b0;
        else pmem_read = 1'b0;
      end
    end
    chk("resp_count", LW'(nresp), LW'(need));
    if (nresp < need) begin
      pmem_read = 1'b0; pmem_write = 1'b0;
      repeat (20) @(posedge clk);
      exp_q.delete(); obs_q.delete();
    end
  endtask

  initial begin
    int lat;
    bit found;
    logic [AW-1:0] a;
    int kind;
    pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
    repeat (3) @(posedge clk); #2;
    chk("rst_mem_read", LW'(mem_read), LW'(0));
    chk("rst_mem_write", LW'(mem_write), LW'(0));
    chk("rst_pmem_resp", LW'(pmem_resp), LW'(0));
    chk("rst_mem_address", LW'(mem_address), LW'(0));
    chk("rst_mem_wdata", LW'(mem_wdata), LW'(0));
    chk("rst_pmem_rdata", pmem_rdata, LW'(0));
    rst_n = 1'b1;

    // Zero-wait read with known beats, latency 5.
    dev_mem[32'h0000_1220] = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    ref_mem[32'h0000_1220] = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    issue(1'b1, 1'b0, 32'h0000_1234, 0, 1, lat);
    chk("read_latency", LW'(lat), LW'(5));

    // Write with an ack every second cycle, then read it back.
    mode = 1;
    issue(1'b0, 1'b1, 32'h0000_3008, 0, 1, lat);
    mode = 0;
    issue(1'b1, 1'b0, 32'h0000_3010, 0, 1, lat);

    // Simultaneous read and write: write first, then read of the new data.
    issue(1'b1, 1'b1, 32'h0000_0100, 0, 1, lat);
    chk("write_first_latency", LW'(lat), LW'(5));

    // Spurious memory acks while idle must not start anything.
    spur_all = 1'b1;
    repeat (6) begin
      @(posedge clk); #2;
      chk("idle_quiet", LW'({mem_read, mem_write, pmem_resp}), LW'(0));
    end
    spur_all = 1'b0;

    // Requests dropped mid-burst still complete.
    mode = 2; spur_en = 1'b1;
    issue(1'b1, 1'b0, 32'h0000_1040, 2, 1, lat);
    issue(1'b0, 1'b1, 32'h0000_1060, 3, 0, lat);
    issue(1'b1, 1'b0, 32'h0000_1060, 0, 0, lat);

    // Reset during beat 2 of a read.
    mode = 0; spur_en = 1'b0;
    @(negedge clk); @(negedge clk);
    pmem_address = 32'h0000_2040; pmem_read = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(posedge clk); #2;
      if (int'(dev_cnt) == 2) found = 1'b1;
    end
    chk("reached_beat2", LW'(found), LW'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_async_mem_read", LW'(mem_read), LW'(0));
    chk("rst_async_pmem_resp", LW'(pmem_resp), LW'(0));
    chk("rst_async_mem_address", LW'(mem_address), LW'(0));
    chk("rst_async_pmem_rdata", pmem_rdata, LW'(0));
    pmem_read = 1'b0;
    last_rd = '0;
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b1;
    issue(1'b1, 1'b0, 32'h0000_2040, 0, 1, lat);
    chk("post_reset_latency", LW'(lat), LW'(5));

    // Randomized traffic over a small line pool.
    spur_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      a    = 32'h0000_1000 + AW'($urandom_range(0, 7) * 32) + AW'($urandom_range(0, 31));
      kind = $urandom_range(0, 19);
      if (kind < 9)       issue(1'b1, 1'b0, a, (kind == 0) ? 2 : 0, $urandom_range(0, 2), lat);
      else if (kind < 18) issue(1'b0, 1'b1, a, (kind == 9) ? 3 : 0, $urandom_range(0, 2), lat);
      else                issue(1'b1, 1'b1, a, 0, $urandom_range(0, 2), lat);
    end

    repeat (8) @(posedge clk); #2;
    chk("exp_drained", LW'(exp_q.size()), LW'(0));
    chk("obs_drained", LW'(obs_q.size()), LW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the run wedges.
  initial begin
    #500_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
